// File: rtl/mult_job_sequencer_pkg.sv
// ============================================================================
// Module  : mult_job_sequencer_pkg
// Brief   : Shared types and constants for the multiply job sequencer.
//           Holds the sequencer FSM state encoding and the width of the
//           completed-job counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_job_sequencer_pkg;

  // Width of the completed-result counter; wraps naturally at 2**JOBS_DONE_W.
  localparam int JOBS_DONE_W = 8;

  // Sequencer FSM states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_t;

endpackage : mult_job_sequencer_pkg

`default_nettype wire

// File: rtl/mult_seq_fifo.sv
// ============================================================================
// Module  : mult_seq_fifo
// Brief   : Synchronous operand FIFO, DEPTH entries of DATA_W bits.
//           No fall-through: a pushed entry becomes visible on pop_data from
//           the following cycle. Simultaneous push and pop both take effect.
//           DEPTH must be a power of two, at least 2.
//           rst is asynchronous and active-low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers; push and pop are independent.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : mult_seq_fifo

`default_nettype wire

// File: rtl/mult_job_sequencer.sv
// ============================================================================
// Module  : mult_job_sequencer
// Brief   : Queues multiply jobs in an operand FIFO and runs them one at a
//           time through an external multiplier (start pulse / level done),
//           returning each product through a valid/ready result port.
//           rst is asynchronous and active-low.
//           Optional build macro MULT_SEQ_ZERO_BYPASS_EN: jobs with a zero
//           operand skip the multiplier and complete with product 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_job_sequencer
  import mult_job_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_multiplier,
  input  logic [WIDTH-1:0]       in_multiplicand,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_multiplier,
  output logic [WIDTH-1:0]       mul_multiplicand,
  input  logic [2*WIDTH-1:0]     mul_product,
  input  logic                   mul_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic                   busy,
  output logic [JOBS_DONE_W-1:0] jobs_done
);

  localparam logic [JOBS_DONE_W-1:0] JOBS_ONE = {{(JOBS_DONE_W-1){1'b0}}, 1'b1};

  seq_state_t               state_q, state_d;
  logic [WIDTH-1:0]         mul_multiplier_q, mul_multiplier_d;
  logic [WIDTH-1:0]         mul_multiplicand_q, mul_multiplicand_d;
  logic [2*WIDTH-1:0]       out_product_q, out_product_d;
  logic [JOBS_DONE_W-1:0]   jobs_done_q, jobs_done_d;
  logic                     ready_en_q, ready_en_d;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [2*WIDTH-1:0]       fifo_wdata;
  logic [2*WIDTH-1:0]       fifo_rdata;
  logic [WIDTH-1:0]         pop_multiplier;
  logic [WIDTH-1:0]         pop_multiplicand;

  // Intake is held off until the first clock after reset release.
  assign in_ready   = ready_en_q & ~fifo_full;
  assign fifo_push  = in_valid & in_ready;
  assign fifo_wdata = {in_multiplier, in_multiplicand};

  assign pop_multiplier   = fifo_rdata[2*WIDTH-1:WIDTH];
  assign pop_multiplicand = fifo_rdata[WIDTH-1:0];

  assign mul_multiplier   = mul_multiplier_q;
  assign mul_multiplicand = mul_multiplicand_q;
  assign out_product      = out_product_q;
  assign jobs_done        = jobs_done_q;
  assign busy             = (state_q != ST_IDLE) | ~fifo_empty;

  mult_seq_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state and outputs: one job at a time, IDLE -> ISSUE -> ARM -> WAIT -> HOLD.
  always_comb begin
    state_d            = state_q;
    mul_multiplier_d   = mul_multiplier_q;
    mul_multiplicand_d = mul_multiplicand_q;
    out_product_d      = out_product_q;
    jobs_done_d        = jobs_done_q;
    ready_en_d         = 1'b1;
    fifo_pop           = 1'b0;
    mul_start          = 1'b0;
    out_valid          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop           = 1'b1;
          mul_multiplier_d   = pop_multiplier;
          mul_multiplicand_d = pop_multiplicand;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
          if ((pop_multiplier == '0) || (pop_multiplicand == '0)) begin
            out_product_d = '0;
            state_d       = ST_HOLD;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end

      ST_ISSUE: begin
        mul_start = 1'b1;
        state_d   = ST_ARM;
      end

      // A done level still high from the previous job must drop first.
      ST_ARM: begin
        if (!mul_done) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mul_done) begin
          out_product_d = mul_product;
          state_d       = ST_HOLD;
        end
      end

      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          jobs_done_d = jobs_done_q + JOBS_ONE;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= ST_IDLE;
      mul_multiplier_q   <= '0;
      mul_multiplicand_q <= '0;
      out_product_q      <= '0;
      jobs_done_q        <= '0;
      ready_en_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      mul_multiplier_q   <= mul_multiplier_d;
      mul_multiplicand_q <= mul_multiplicand_d;
      out_product_q      <= out_product_d;
      jobs_done_q        <= jobs_done_d;
      ready_en_q         <= ready_en_d;
    end
  end

endmodule : mult_job_sequencer

`default_nettype wire

// File: doc/mult_job_sequencer.md
MULT_JOB_SEQUENCER -- requirements
Module: mult_job_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; products are 2*WIDTH bits.
REQ-002 SHALL have parameter DEPTH, default 4: operand FIFO depth in entries, power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1: job-intake handshake; a transfer occurs on a cycle where both are high.
REQ-006 SHALL have ports in_multiplier input WIDTH / in_multiplicand input WIDTH: job operands, sampled on transfer.
REQ-007 SHALL have port mul_start  output  1: one-cycle start pulse to the downstream multiplier.
REQ-008 SHALL have ports mul_multiplier output WIDTH / mul_multiplicand output WIDTH: operands presented to the multiplier.
REQ-009 SHALL have ports mul_product input 2*WIDTH / mul_done input 1: multiplier result and its level-type done flag.
REQ-010 SHALL have ports out_valid output 1 / out_ready input 1 / out_product output 2*WIDTH: result handshake.
REQ-011 SHALL have port busy  output  1: high whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-012 SHALL have port jobs_done  output  8: count of completed results, incremented on each output transfer, wraps 255->0.

Function
REQ-013 SHALL buffer jobs in a DEPTH-entry FIFO; in_ready = not full; there is no fall-through, so a pushed entry is poppable from the next cycle onward.
REQ-014 SHALL use FSM states IDLE, ISSUE, ARM, WAIT, HOLD.
REQ-015 IDLE: FIFO non-empty -> pop, register the operands onto mul_multiplier/mul_multiplicand, go to ISSUE.
REQ-016 ISSUE: mul_start=1 for exactly this cycle, then go to ARM.
REQ-017 ARM: wait for mul_done=0, which rejects a stale done level; on that cycle go to WAIT.
REQ-018 WAIT: on the first cycle with mul_done=1, capture mul_product into out_product and go to HOLD.
REQ-019 HOLD: out_valid=1 with out_product stable; when out_ready=1, increment jobs_done and go to IDLE.
REQ-020 mul_multiplier/mul_multiplicand SHALL stay stable from ISSUE until leaving WAIT.
REQ-021 At most one job SHALL be in flight; intake continues while the FSM is busy.
REQ-022 A push and a pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-023 Minimum latency from intake transfer to out_valid SHALL be 4 cycles plus the multiplier's done latency.

Reset
REQ-024 Reset asserted SHALL asynchronously force: FSM to IDLE; FIFO empty; mul_start=0; out_valid=0; out_product=0; mul_operands=0; jobs_done=0; busy=0; in_ready=1 from the first clock after release.
REQ-025 Reset during any state SHALL discard the in-flight job and all queued jobs without producing a result.

Configuration
REQ-026 With macro MULT_SEQ_ZERO_BYPASS_EN defined: in IDLE, a popped job with either operand zero SHALL go directly to HOLD with out_product=0, and no mul_start is issued.
REQ-027 Without MULT_SEQ_ZERO_BYPASS_EN: every job, including zero operands, SHALL go through ISSUE/ARM/WAIT.

Structure
REQ-028 A shared package/header SHALL hold the FSM state encoding and the jobs_done width constant (8).
REQ-029 The FIFO SHALL be a sub-module named mult_seq_fifo, parameterised by data width (2*WIDTH) and DEPTH.

Verification
REQ-030 WIDTH=4, push 3x5, multiplier model done after 6 cycles -> one mul_start pulse, out_product=0x0F, jobs_done=1.
REQ-031 Push 5 jobs back-to-back while the first is in flight -> in_ready low on the 5th attempt when the FIFO is full, results emerge in order.
REQ-032 out_ready held low 10 cycles in HOLD -> out_valid stays high, out_product=0x0F stable, no new mul_start.
REQ-033 Push 0x0 x 0x9 -> with MULT_SEQ_ZERO_BYPASS_EN defined: out_product=0x00 and no mul_start; without it: a mul_start pulse, then 0x00.
REQ-034 mul_done held high from before ISSUE, then low 1 cycle, then high with 0x23 -> only 0x23 captured.
REQ-035 Assert rst while in WAIT with 2 jobs queued -> mul_start=0, out_valid=0, busy=0, no result ever emitted for those jobs.
